imem_uart_loader: RTL and testbench

//  UART boot loader sitting directly upstream of the instruction memory write port.
//  - Receives a framed program image over a serial RX line.
//  - Assembles 32-bit little-endian words and drives the memory's WE/A/WD.
//  - Holds the core in reset while loading; releases it once the image is complete.

---
 rtl/imem_uart_loader_pkg.sv | 27 ++
 rtl/imem_uart_loader_if.sv | 12 +
 rtl/imem_uart_loader_uart_rx.sv | 93 +++++++++
 rtl/imem_uart_loader.sv | 117 +++++++++++
 tb/tb_imem_uart_loader.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared constants for the UART boot loader: loader and receiver state encodings,
// default frame parameters and the word-to-byte-address helper.
package imem_uart_loader_pkg;

    localparam int          DATA_BITS     = 8;
    localparam logic [7:0]  SYNC_BYTE_DEF = 8'hA5;
    localparam int unsigned MAX_WORDS_DEF = 14;

    typedef logic [2:0] loader_state_t;
    localparam loader_state_t ST_WAIT_SYNC = 3'd0;
    localparam loader_state_t ST_GET_LEN   = 3'd1;
    localparam loader_state_t ST_GET_DATA  = 3'd2;
    localparam loader_state_t ST_WRITE     = 3'd3;
    localparam loader_state_t ST_DONE      = 3'd4;
    localparam loader_state_t ST_ERROR     = 3'd5;

    typedef logic [1:0] rx_state_t;
    localparam rx_state_t RX_IDLE  = 2'd0;
    localparam rx_state_t RX_START = 2'd1;
    localparam rx_state_t RX_DATA  = 2'd2;
    localparam rx_state_t RX_STOP  = 2'd3;

    function automatic logic [31:0] word_addr(input logic [3:0] idx);
        return {26'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_uart_loader_if.sv
// Instruction-memory write port plus core hand-off status driven by the boot loader.
interface imem_uart_loader_if;
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic        loading;
    logic        core_rst_n;
    logic        load_err;

    modport master (output we, a, wd, loading, core_rst_n, load_err);
    modport slave  (input  we, a, wd, loading, core_rst_n, load_err);
endinterface

// File: rtl/imem_uart_loader_uart_rx.sv
// 8N1 UART receiver: synchronised RX, mid-bit sampling via a down-counter,
// one-cycle rx_valid or rx_ferr pulse at the stop-bit sample.
module uart_rx
    import imem_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

    logic        rx_meta;
    logic        rx_s;
    logic        rx_prev;
    rx_state_t   state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            rx_byte  <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_meta  <= rx;
            rx_s     <= rx_meta;
            rx_prev  <= rx_s;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= HALF_CNT;
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        // start bit went high again by mid-bit: a glitch, not a frame
                        state <= RX_IDLE;
                    end else begin
                        cnt     <= FULL_CNT;
                        bit_idx <= '0;
                        state   <= RX_DATA;
                    end
                end
                RX_DATA: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= FULL_CNT;
                        if (bit_idx == LAST_BIT) state <= RX_STOP;
                        else                     bit_idx <= bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (cnt != 16'd0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        if (rx_s) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shreg;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/imem_uart_loader.sv
// UART boot loader: parses SYNC/N/data frames, writes little-endian words into
// instruction memory and holds the core in reset until a full image is loaded.
module imem_uart_loader
    import imem_uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 87,
    parameter int unsigned MAX_WORDS    = MAX_WORDS_DEF,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx,
    imem_uart_loader_if.master imem
);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          rx_ferr;
    loader_state_t state;
    logic [3:0]    n_words;
    logic [3:0]    word_idx;
    logic [1:0]    byte_idx;
    logic [23:0]   word_reg;
    logic          sync_seen;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_byte  (rx_byte),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign sync_seen = rx_valid && (rx_byte == SYNC_BYTE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ST_WAIT_SYNC;
            n_words         <= '0;
            word_idx        <= '0;
            byte_idx        <= '0;
            word_reg        <= '0;
            imem.we         <= 1'b0;
            imem.a          <= '0;
            imem.wd         <= '0;
            imem.loading    <= 1'b1;
            imem.core_rst_n <= 1'b0;
            imem.load_err   <= 1'b0;
        end else begin
            imem.we <= 1'b0;
            case (state)
                ST_WAIT_SYNC: begin
                    if (sync_seen) state <= ST_GET_LEN;
                end
                ST_GET_LEN: begin
                    if (rx_valid) begin
                        if (rx_byte == 8'd0 || {24'd0, rx_byte} > MAX_WORDS) begin
                            imem.load_err <= 1'b1;
                            state         <= ST_ERROR;
                        end else begin
                            n_words  <= rx_byte[3:0];
                            word_idx <= '0;
                            byte_idx <= '0;
                            state    <= ST_GET_DATA;
                        end
                    end
                end
                ST_GET_DATA: begin
                    if (rx_ferr) begin
                        imem.load_err <= 1'b1;
                        state         <= ST_ERROR;
                    end else if (rx_valid) begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: word_reg[7:0]   <= rx_byte;
                            2'd1: word_reg[15:8]  <= rx_byte;
                            2'd2: word_reg[23:16] <= rx_byte;
                            default: begin
                                // the top byte goes straight to the write port
                                imem.we <= 1'b1;
                                imem.a  <= word_addr(word_idx);
                                imem.wd <= {rx_byte, word_reg};
                                state   <= ST_WRITE;
                            end
                        endcase
                    end
                end
                ST_WRITE: begin
                    word_idx <= word_idx + 4'd1;
                    if (word_idx == n_words - 4'd1) begin
                        imem.loading    <= 1'b0;
                        imem.core_rst_n <= 1'b1;
                        state           <= ST_DONE;
                    end else begin
                        state <= ST_GET_DATA;
                    end
                end
                ST_DONE: begin
                    if (sync_seen) begin
                        imem.loading    <= 1'b1;
                        imem.core_rst_n <= 1'b0;
                        state           <= ST_GET_LEN;
                    end
                end
                ST_ERROR: begin
                    if (sync_seen) begin
                        imem.load_err <= 1'b0;
                        state         <= ST_GET_LEN;
                    end
                end
                default: state <= ST_WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader at 8 clocks per UART bit.
module tb_imem_uart_loader;
    import imem_uart_loader_pkg::*;

    localparam int CPB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx = 1'b1;

    imem_uart_loader_if imem();

    imem_uart_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(14), .SYNC_BYTE(8'hA5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (rx),
        .imem  (imem)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [31:0] a_q[$];
    logic [31:0] wd_q[$];
    int          rst_at_we;
    int          rv_cnt;
    logic        post_pending;
    logic        post_rst;
    logic        post_load;

    initial begin
        rst_at_we    = 0;
        rv_cnt       = 0;
        post_pending = 1'b0;
        post_rst     = 1'b0;
        post_load    = 1'b1;
    end

    always @(negedge clk) begin
        if (post_pending) begin
            post_rst  = imem.core_rst_n;
            post_load = imem.loading;
        end
        post_pending = 1'b0;
        if (imem.we === 1'b1) begin
            a_q.push_back(imem.a);
            wd_q.push_back(imem.wd);
            if (imem.core_rst_n === 1'b1) rst_at_we++;
            post_pending = 1'b1;
        end
        if (dut.rx_valid === 1'b1) rv_cnt++;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
    endtask

    task automatic clear_log();
        a_q.delete();
        wd_q.delete();
        rst_at_we = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we"},     32'(imem.we),         32'd0);
        chk({tag, "_a"},      imem.a,               32'd0);
        chk({tag, "_wd"},     imem.wd,              32'd0);
        chk({tag, "_load"},   32'(imem.loading),    32'd1);
        chk({tag, "_corerst"},32'(imem.core_rst_n), 32'd0);
        chk({tag, "_err"},    32'(imem.load_err),   32'd0);
        chk({tag, "_state"},  32'(dut.state),       32'(ST_WAIT_SYNC));
    endtask

    initial begin
        int rv_before;
        repeat (4) @(negedge clk);
        chk_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: single-word image
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h0010_0093);
        chk("t1_we_count", 32'(a_q.size()), 32'd1);
        if (a_q.size() == 1) begin
            chk("t1_a",  a_q[0],  32'h0);
            chk("t1_wd", wd_q[0], 32'h0010_0093);
        end
        chk("t1_rst_at_we",  32'(rst_at_we), 32'd0);
        chk("t1_post_rst",   32'(post_rst),  32'd1);
        chk("t1_post_load",  32'(post_load), 32'd0);
        chk("t1_err",        32'(imem.load_err), 32'd0);

        // 2: maximum image, re-entered from DONE
        clear_log();
        send_byte(8'hA5, 1'b1);
        chk("t2_resync_load",    32'(imem.loading),    32'd1);
        chk("t2_resync_corerst", 32'(imem.core_rst_n), 32'd0);
        send_byte(8'h0E, 1'b1);
        for (int i = 0; i < 14; i++) send_word(32'h100 + 32'(i));
        chk("t2_we_count", 32'(a_q.size()), 32'd14);
        for (int i = 0; i < 14 && i < a_q.size(); i++) begin
            chk($sformatf("t2_a%0d", i),  a_q[i],  32'(i * 4));
            chk($sformatf("t2_wd%0d", i), wd_q[i], 32'h100 + 32'(i));
        end
        chk("t2_rst_at_we", 32'(rst_at_we), 32'd0);
        chk("t2_post_rst",  32'(post_rst),  32'd1);
        chk("t2_corerst",   32'(imem.core_rst_n), 32'd1);

        // 3: oversize length then recovery
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h0F, 1'b1);
        chk("t3_err",        32'(imem.load_err),   32'd1);
        chk("t3_corerst",    32'(imem.core_rst_n), 32'd0);
        chk("t3_we_count",   32'(a_q.size()),      32'd0);
        send_byte(8'hA5, 1'b1);
        chk("t3_err_clr",    32'(imem.load_err),   32'd0);
        send_byte(8'h01, 1'b1);
        send_word(32'hDEAD_BEEF);
        chk("t3_we_count2",  32'(a_q.size()),      32'd1);
        if (a_q.size() == 1) begin
            chk("t3_a",  a_q[0],  32'h0);
            chk("t3_wd", wd_q[0], 32'hDEAD_BEEF);
        end
        chk("t3_corerst2",   32'(imem.core_rst_n), 32'd1);

        // 4: framing error in the second word
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h02, 1'b1);
        send_word(32'h4433_2211);
        send_byte(8'h55, 1'b0);
        chk("t4_we_count", 32'(a_q.size()), 32'd1);
        if (a_q.size() == 1) chk("t4_wd", wd_q[0], 32'h4433_2211);
        chk("t4_err",     32'(imem.load_err),   32'd1);
        chk("t4_corerst", 32'(imem.core_rst_n), 32'd0);
        chk("t4_load",    32'(imem.loading),    32'd1);
        chk("t4_state",   32'(dut.state),       32'(ST_ERROR));

        // 5: short glitch while idle, then the sync value as data
        clear_log();
        rv_before = rv_cnt;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (5 * CPB) @(negedge clk);
        chk("t5_glitch_rv",    32'(rv_cnt - rv_before), 32'd0);
        chk("t5_glitch_state", 32'(dut.state),          32'(ST_ERROR));
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h00A5_5AA5);
        chk("t5_we_count", 32'(a_q.size()), 32'd1);
        if (a_q.size() == 1) chk("t5_wd", wd_q[0], 32'h00A5_5AA5);
        chk("t5_corerst",  32'(imem.core_rst_n), 32'd1);
        chk("t5_err",      32'(imem.load_err),   32'd0);

        // 6: reset mid-word, then a fresh load
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        send_byte(8'h33, 1'b1);
        send_byte(8'h33, 1'b1);
        chk("t6_pre_we_count", 32'(a_q.size()), 32'd2);
        chk("t6_pre_a",        imem.a,          32'h4);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("t6_rst");
        clear_log();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_word(32'h1234_5678);
        chk("t6_we_count", 32'(a_q.size()), 32'd1);
        if (a_q.size() == 1) begin
            chk("t6_a",  a_q[0],  32'h0);
            chk("t6_wd", wd_q[0], 32'h1234_5678);
        end
        chk("t6_corerst", 32'(imem.core_rst_n), 32'd1);
        chk("t6_load",    32'(imem.loading),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
